// File: rtl/uvma_mio_cli_dut_pkg.sv
// Shared types and helpers for the mio_cli request/response slave.
// Holds the response record, the control FSM encoding and pointer-width sizing.
package uvma_mio_cli_dut_pkg;

    localparam int RSP_DATA_W = 32;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FULL   = 2'd3
    } state_t;

    // Index width for a table of 'depth' entries (never below one bit).
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uvma_mio_cli_rsp_fifo.sv
// First-word-fall-through response FIFO: the head entry is presented on rdata
// whenever the FIFO is not empty; DEPTH must be a power of two so pointers wrap freely.
module uvma_mio_cli_rsp_fifo
    import uvma_mio_cli_dut_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    localparam int CW = PTR_W + 1;
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

endmodule

// File: rtl/uvma_mio_cli_dut_slv.sv
// mio_cli reference slave: word-addressed register file, address decode, control FSM,
// saturating statistics and an in-order buffered response channel.
module uvma_mio_cli_dut_slv
    import uvma_mio_cli_dut_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 64,
    parameter int RSP_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  stat_req_cnt,
    output logic [CNT_W-1:0]  stat_err_cnt
);

    localparam int PTR_W = ptr_w(RSP_DEPTH);
    localparam int IDX_W = ptr_w(NUM_WORDS);
    localparam int RSP_W = DATA_W + 1;
    localparam int CW    = PTR_W + 1;
    localparam logic [CW-1:0]    CNT_FULL = CW'(RSP_DEPTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

    state_t            state_reg;
    state_t            state_next;
    logic [CW-1:0]     cnt_next;

    logic [DATA_W-1:0] word_q [NUM_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              accept;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] rd_word;
    logic [RSP_W-1:0]  push_data;

    logic [RSP_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    logic [CNT_W-1:0]  req_cnt_reg;
    logic [CNT_W-1:0]  err_cnt_reg;

    assign in_range  = (32'(req_addr) < 32'(NUM_WORDS));
    assign idx       = req_addr[IDX_W-1:0];
    assign accept    = req_valid && req_ready;
    assign push      = accept && !fifo_full;
    assign pop       = rsp_valid && rsp_ready;
    assign rd_word   = word_q[idx];
    assign push_data = {(in_range && !req_we) ? rd_word : {DATA_W{1'b0}}, !in_range};

    // Register file: one flop word per address so the whole table clears on reset.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            logic [DATA_W-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (accept && req_we && in_range && (idx == IDX_W'(gi))) begin
                    word_reg <= req_wdata;
                end
            end

            assign word_q[gi] = word_reg;
        end
    endgenerate

    uvma_mio_cli_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .srst  (reset),
        .push  (push),
        .pop   (pop),
        .wdata (push_data),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Outputs read zero whenever no response is pending, hiding stale storage.
    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = rsp_valid ? fifo_head[RSP_W-1:1] : '0;
    assign rsp_err   = rsp_valid && fifo_head[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        cnt_next   = fifo_count;
        state_next = state_reg;
        if (push && !pop) begin
            cnt_next = fifo_count + CNT_ONE;
        end else if (pop && !push) begin
            cnt_next = fifo_count - CNT_ONE;
        end
        case (state_reg)
            ST_RESET: state_next = ST_IDLE;
            ST_IDLE: begin
                if (push && !pop) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cnt_next == CNT_FULL) begin
                    state_next = ST_FULL;
                end else if (cnt_next == '0) begin
                    state_next = ST_IDLE;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_next = ST_ACTIVE;
                end
            end
            default: state_next = ST_RESET;
        endcase
    end

    // Ready depends on registered state only, so a pop never reaches req_ready in the same cycle.
    always_comb begin
        req_ready = (state_reg == ST_IDLE) || (state_reg == ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else if (accept) begin
            if (req_cnt_reg != '1) begin
                req_cnt_reg <= req_cnt_reg + STAT_ONE;
            end
            if (!in_range && (err_cnt_reg != '1)) begin
                err_cnt_reg <= err_cnt_reg + STAT_ONE;
            end
        end
    end

    assign stat_req_cnt = req_cnt_reg;
    assign stat_err_cnt = err_cnt_reg;

endmodule

// File: doc/uvma_mio_cli_dut_slv.md
Name: uvma_mio_cli_dut_slv

Overview:
- Synthesizable request/response slave that sits directly downstream of the mio_cli agent interface and consumes the requests the agent drives.
- Holds a small word-addressed register file, executes reads and writes, and returns in-order responses through a buffered response channel.
- Serves as the reference endpoint for the mio_cli e2e bench, and as the RTL target of the interface assertion checker.

Parameters:
- ADDR_W, 8, request address width in bits
- DATA_W, 32, data width in bits
- NUM_WORDS, 64, implemented register-file words; valid addresses are 0..NUM_WORDS-1
- RSP_DEPTH, 4, response FIFO depth; must be a power of 2 and at least 2
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  slave can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  address out of range
- stat_req_cnt  out  CNT_W  accepted requests, saturating
- stat_err_cnt  out  CNT_W  error responses, saturating

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values:
  - req_ready=0 during reset, 1 on the first cycle after reset deasserts.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Both stat counters = 0.
  - FIFO empty.
  - Register-file contents are also cleared to 0.
- Request acceptance:
  - A request is accepted on a cycle with req_valid && req_ready.
  - req_ready = !reset_q && (fifo_count < RSP_DEPTH), driven from registered state only. There is no combinational path from rsp_ready.
- Execution, in the acceptance cycle:
  - addr < NUM_WORDS, write: mem[addr] <= wdata; the response is {rdata=0, err=0}.
  - addr < NUM_WORDS, read: the response is {rdata=mem[addr], err=0}. A read returns the pre-write value of the same cycle; reads and writes are never simultaneous because there is one request per cycle.
  - addr >= NUM_WORDS: no write occurs; the response is {rdata=0, err=1}.
- Response path:
  - The response is pushed into the FIFO at the end of the acceptance cycle, so rsp_valid is visible 1 cycle after acceptance at the earliest.
  - The FIFO is first-word-fall-through: rsp_rdata and rsp_err reflect the head entry whenever rsp_valid=1.
  - A pop occurs on rsp_valid && rsp_ready.
- Simultaneous push and pop: fifo_count is unchanged. When full, a pop in cycle N raises req_ready in cycle N+1, not in cycle N.
- Handshake rules:
  - Once rsp_valid=1, the head entry and rsp_valid stay stable until popped.
  - req_* inputs are ignored when req_ready=0.
- Pointers: wrap modulo RSP_DEPTH. The count is (log2(RSP_DEPTH)+1) bits wide.
- Counters:
  - stat_req_cnt increments on each accept.
  - stat_err_cnt increments on each accept whose address is out of range.
  - Both saturate at all-ones.
- Reset mid-operation:
  - Pending responses are discarded and rsp_valid drops in the cycle after reset is sampled.
  - Any request presented during reset is not accepted.
- Internal FSM (slave control):
  - States: RESET, IDLE (FIFO empty), ACTIVE (0 < count < RSP_DEPTH), FULL.
  - RESET -> IDLE on the first cycle with reset=0.
  - IDLE -> ACTIVE on a push without a pop.
  - ACTIVE -> FULL when count reaches RSP_DEPTH.
  - FULL -> ACTIVE on a pop.
  - ACTIVE -> IDLE when count reaches 0.
  - Any state -> RESET on reset.
  - req_ready=1 in IDLE and ACTIVE only.

Decomposition:
- Package uvma_mio_cli_dut_pkg holds:
  - the typedef of the response struct {logic [DATA_W-1:0] rdata; logic err;};
  - the state enum {RESET, IDLE, ACTIVE, FULL};
  - the localparam function for clog2-based pointer widths.
- Sub-module uvma_mio_cli_rsp_fifo: a parameterized FWFT FIFO with push, pop, full, empty and count.
- The top level holds the register file, decode, FSM and counters.

Test Plan:
- Write then read: write 0xDEADBEEF to address 5 (req_valid=1, rsp_ready=1) -> rsp 1 cycle later {rdata=0, err=0}. Read address 5 -> rsp {0xDEADBEEF, 0}. stat_req_cnt=2.
- Out of range: write 0x1234 to address 64, then read address 64 -> both responses have err=1, rdata=0. stat_err_cnt=2. A read of address 0 still returns 0.
- Backpressure: hold rsp_ready=0 and issue 6 back-to-back reads -> exactly 4 accepted and req_ready=0 from cycle 5. Release rsp_ready -> responses drain in order, and req_ready=1 one cycle after the first pop.
- Simultaneous push and pop: with FIFO count=4, assert rsp_ready=1 and req_valid=1 for 10 cycles -> steady one accept per cycle after the first pop cycle. Count never exceeds 4, and no response is lost or reordered.
- Reset mid-stream: with 3 responses pending, assert reset for 1 cycle -> rsp_valid=0, stat counters=0, req_ready=0. Next cycle req_ready=1, and a read of a previously written address returns 0.
- Saturation: with CNT_W=4, issue 20 out-of-range requests -> stat_req_cnt=15 and stat_err_cnt=15, with no wrap.
